// File: rtl/l2_dbgbus_tx.sv
// l2_dbgbus_tx: per-bank L2 debug-bus source. It selects one debug source, qualifies it
// (continuous or triggered burst), buffers it in a FIFO and re-presents collided words.
module l2_dbgbus_tx #(
    parameter int DW    = 40,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4,
    parameter int HIPRI = 1
) (
    input  logic                    rclk,
    input  logic                    arst_l,
    input  logic [NSRC*DW-1:0]      src_data,
    input  logic [NSRC-1:0]         src_vld,
    input  logic                    csr_en,
    input  logic [$clog2(NSRC)-1:0] csr_sel,
    input  logic                    csr_mode,
    input  logic [7:0]              csr_blen,
    input  logic                    trig_in,
    input  logic                    peer_vld,
    output logic [DW:0]             dbgbus_out,
    output logic [7:0]              ovf_cnt,
    output logic                    burst_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic HP = (HIPRI != 0);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, BURST = 2'd2, DONE = 2'd3;

    logic [1:0]    r_state;
    logic [8:0]    r_bcnt;
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          r_out_vld;
    logic [DW-1:0] r_out_dat;
    logic [7:0]    r_ovf;

    logic [DW-1:0] w_src [NSRC];
    logic [DW-1:0] w_sd;
    logic          w_sv, w_cap, w_full, w_empty, w_load, w_pop, w_push, w_drop;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign w_src[i] = src_data[i*DW +: DW];
    end

    assign w_sv    = src_vld[csr_sel];
    assign w_sd    = w_src[csr_sel];
    assign w_full  = r_cnt == FULL;
    assign w_empty = r_cnt == '0;
    assign w_cap   = csr_en & w_sv & (~csr_mode | (r_state == BURST));
    // The register reloads when empty or when the repeater took the word; bank 0 always wins.
    assign w_load  = csr_en & (~r_out_vld | HP | ~peer_vld);
    assign w_pop   = w_load & ~w_empty;
    assign w_push  = w_cap & (~w_full | w_pop);
    assign w_drop  = w_cap & w_full & ~w_pop;

    always_ff @(posedge rclk) begin
        if (w_push)
            r_mem[r_wp] <= w_sd;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (!csr_en) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_out_vld <= 1'b0;
            r_out_dat <= '0;
        end else if (!csr_en) begin
            r_out_vld <= 1'b0;
        end else if (w_load) begin
            r_out_vld <= w_pop;
            if (w_pop)
                r_out_dat <= r_mem[r_rp];
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l)
            r_ovf <= 8'd0;
        else if (w_drop && r_ovf != 8'hFF)
            r_ovf <= r_ovf + 8'd1;
    end

    // Burst counter counts every valid source cycle, captured or dropped.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
        end else if (!csr_en) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:
                    if (csr_mode)
                        r_state <= ARMED;
                ARMED:
                    if (trig_in) begin
                        r_state <= BURST;
                        r_bcnt  <= (csr_blen == 8'd0) ? 9'd256 : {1'b0, csr_blen};
                    end
                BURST:
                    if (w_sv) begin
                        r_bcnt <= r_bcnt - 9'd1;
                        if (r_bcnt == 9'd1)
                            r_state <= DONE;
                    end
                default: ;
            endcase
        end
    end

    assign dbgbus_out = {r_out_vld, r_out_dat};
    assign ovf_cnt    = r_ovf;
    assign burst_done = r_state == DONE;
endmodule

// File: tb/tb_l2_dbgbus_tx.sv
// tb_l2_dbgbus_tx: checks a bank-0 and a bank-1 instance against a queue-level model
// every cycle, plus hand-computed expectations from directed scenarios.
module tb_l2_dbgbus_tx;
    logic         rclk = 1'b0, arst_l = 1'b1;
    logic [159:0] src_data = '0;
    logic [3:0]   src_vld = '0;
    logic         csr_en = 1'b0, csr_mode = 1'b0, trig_in = 1'b0, peer_vld = 1'b0;
    logic [1:0]   csr_sel = '0;
    logic [7:0]   csr_blen = '0;
    logic [40:0]  hi_bus, lo_bus;
    logic [7:0]   hi_ovf, lo_ovf;
    logic         hi_done, lo_done;
    int           total = 0, bad = 0;

    always #5 rclk = ~rclk;

    l2_dbgbus_tx #(.DW(40), .NSRC(4), .DEPTH(4), .HIPRI(1)) u_hi (
        .rclk(rclk), .arst_l(arst_l), .src_data(src_data), .src_vld(src_vld),
        .csr_en(csr_en), .csr_sel(csr_sel), .csr_mode(csr_mode), .csr_blen(csr_blen),
        .trig_in(trig_in), .peer_vld(peer_vld), .dbgbus_out(hi_bus), .ovf_cnt(hi_ovf),
        .burst_done(hi_done));

    l2_dbgbus_tx #(.DW(40), .NSRC(4), .DEPTH(4), .HIPRI(0)) u_lo (
        .rclk(rclk), .arst_l(arst_l), .src_data(src_data), .src_vld(src_vld),
        .csr_en(csr_en), .csr_sel(csr_sel), .csr_mode(csr_mode), .csr_blen(csr_blen),
        .trig_in(trig_in), .peer_vld(peer_vld), .dbgbus_out(lo_bus), .ovf_cnt(lo_ovf),
        .burst_done(lo_done));

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
        end
    endtask

    // Model: index 0 = bank-1 (retrying) instance, index 1 = bank-0 instance.
    localparam int P_IDLE = 0, P_ARM = 1, P_BURST = 2, P_DONE = 3;
    logic [39:0] mf [2][4];
    int          mn [2];
    logic        mov [2];
    logic [39:0] md [2];
    int          movf [2];
    int          mph [2];
    int          mbc [2];

    task automatic step(input int h);
        int sel;
        logic sv, cap, take, popped;
        logic [39:0] sd, head;
        sel = int'(csr_sel);
        sv = src_vld[sel];
        sd = src_data[sel*40 +: 40];
        if (!csr_en) begin
            mn[h] = 0;
            mov[h] = 1'b0;
            mph[h] = P_IDLE;
            return;
        end
        cap = sv && (!csr_mode || mph[h] == P_BURST);
        take = !mov[h] || (h == 1) || !peer_vld;
        popped = take && mn[h] > 0;
        head = mf[h][0];
        if (popped) begin
            for (int i = 0; i < 3; i++) mf[h][i] = mf[h][i+1];
            mn[h]--;
        end
        if (cap) begin
            if (mn[h] < 4) begin
                mf[h][mn[h]] = sd;
                mn[h]++;
            end else if (movf[h] < 255) movf[h]++;
        end
        if (take) begin
            mov[h] = popped;
            if (popped) md[h] = head;
        end
        if (mph[h] == P_IDLE && csr_mode) mph[h] = P_ARM;
        else if (mph[h] == P_ARM && trig_in) begin
            mph[h] = P_BURST;
            mbc[h] = (csr_blen == 8'd0) ? 256 : int'(csr_blen);
        end else if (mph[h] == P_BURST && sv) begin
            mbc[h]--;
            if (mbc[h] == 0) mph[h] = P_DONE;
        end
    endtask

    always @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int h = 0; h < 2; h++) begin
                mn[h] = 0; mov[h] = 1'b0; md[h] = '0; movf[h] = 0; mph[h] = P_IDLE; mbc[h] = 0;
            end
        end else begin
            step(0);
            step(1);
        end
    end

    always @(negedge rclk) begin
        chk("cmp_hi_bus", 64'(hi_bus), 64'({mov[1], md[1]}));
        chk("cmp_lo_bus", 64'(lo_bus), 64'({mov[0], md[0]}));
        chk("cmp_hi_ovf", 64'(hi_ovf), 64'(movf[1]));
        chk("cmp_lo_ovf", 64'(lo_ovf), 64'(movf[0]));
        chk("cmp_hi_done", 64'(hi_done), 64'(mph[1] == P_DONE));
        chk("cmp_lo_done", 64'(lo_done), 64'(mph[0] == P_DONE));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [39:0] d);
        src_data[s*40 +: 40] = d;
    endtask

    initial begin
        #2 arst_l = 1'b0;
        tick(2);
        arst_l = 1'b1;
        chk("rst_bus", 64'(hi_bus), 64'h0);
        chk("rst_ovf", 64'(lo_ovf), 64'h0);
        chk("rst_done", 64'(hi_done), 64'h0);

        // continuous capture from source 2 while other sources carry junk
        set_src(0, 40'h0DEAD0); set_src(1, 40'h0DEAD1); set_src(3, 40'h0DEAD3);
        src_vld = 4'b1011;
        csr_en = 1'b1; csr_mode = 1'b0; csr_sel = 2'd2;
        for (int i = 0; i < 6; i++) begin
            set_src(2, 40'h10 + 40'(i));
            src_vld[2] = 1'b1;
            tick(1);
            if (i > 0) chk("m0_word", 64'(hi_bus), 64'h100_0000_0010 + 64'(i - 1));
        end
        src_vld[2] = 1'b0;
        tick(1);
        chk("m0_last", 64'(hi_bus), 64'h100_0000_0015);
        tick(1);
        chk("m0_idle_hold", 64'(hi_bus), 64'h15);
        chk("m0_ovf", 64'(hi_ovf), 64'h0);
        csr_en = 1'b0;
        tick(1);

        // triggered burst of 3
        csr_sel = 2'd1; csr_mode = 1'b1; csr_blen = 8'd3; src_vld[1] = 1'b1;
        csr_en = 1'b1;
        tick(1);
        for (int j = 0; j < 12; j++) begin
            set_src(1, 40'h200 + 40'(j));
            trig_in = (j == 3 || j == 10);
            tick(1);
            if (j == 5) chk("b_w0", 64'(hi_bus), 64'h100_0000_0204);
            if (j == 6) chk("b_w1", 64'(hi_bus), 64'h100_0000_0205);
            if (j == 7) chk("b_w2", 64'(hi_bus), 64'h100_0000_0206);
            if (j == 8 || j == 11) chk("b_end_vld", 64'(hi_bus[40]), 64'h0);
            if (j == 5) chk("b_done_early", 64'(hi_done), 64'h0);
            if (j == 6 || j == 11) chk("b_done", 64'(hi_done), 64'h1);
        end
        trig_in = 1'b0; csr_en = 1'b0;
        tick(1);
        chk("b_done_clr", 64'(hi_done), 64'h0);

        // collision hold on the retrying instance
        csr_mode = 1'b0; csr_sel = 2'd0; src_vld[0] = 1'b0; csr_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            src_vld[0] = (j < 3);
            set_src(0, 40'hAA + 40'(j));
            peer_vld = (j >= 2 && j <= 4);
            tick(1);
            if (j >= 1 && j <= 4) chk("col_hold", 64'(lo_bus), 64'h100_0000_00AA);
            if (j == 5) chk("col_next", 64'(lo_bus), 64'h100_0000_00AB);
            if (j == 6) chk("col_last", 64'(lo_bus), 64'h100_0000_00AC);
            if (j == 7) chk("col_empty", 64'(lo_bus[40]), 64'h0);
            if (j == 2) chk("hi_ignores_peer", 64'(hi_bus), 64'h100_0000_00AB);
        end

        // stuck collision: fill and overflow
        peer_vld = 1'b1; csr_sel = 2'd3;
        for (int j = 0; j < 10; j++) begin
            src_vld[3] = 1'b1;
            set_src(3, 40'h300 + 40'(j));
            tick(1);
        end
        chk("ovf5", 64'(lo_ovf), 64'h5);
        chk("ovf_hi0", 64'(hi_ovf), 64'h0);
        chk("stuck_word", 64'(lo_bus), 64'h100_0000_0300);
        src_vld[3] = 1'b0; peer_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (k < 4) chk("drain", 64'(lo_bus), 64'h100_0000_0301 + 64'(k));
            else chk("drain_end", 64'(lo_bus[40]), 64'h0);
        end

        // disable mid-burst with words buffered
        csr_en = 1'b0; src_vld[1] = 1'b0;
        tick(1);
        csr_mode = 1'b1; csr_blen = 8'd8; csr_sel = 2'd1; csr_en = 1'b1;
        tick(1);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0; peer_vld = 1'b1; src_vld[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_src(1, 40'h500 + 40'(j));
            tick(1);
        end
        csr_en = 1'b0;
        tick(1);
        chk("dis_lo_vld", 64'(lo_bus[40]), 64'h0);
        chk("dis_hi_vld", 64'(hi_bus[40]), 64'h0);
        chk("dis_ovf_kept", 64'(lo_ovf), 64'h5);
        csr_en = 1'b1;
        tick(2);
        chk("rearm_no_cap", 64'(lo_bus[40]), 64'h0);
        peer_vld = 1'b0; set_src(1, 40'h600); trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(2);
        chk("rearm_hi", 64'(hi_bus), 64'h100_0000_0600);
        chk("rearm_lo", 64'(lo_bus), 64'h100_0000_0600);
        csr_en = 1'b0;
        tick(1);

        // burst length 0 means 256
        csr_blen = 8'd0; csr_sel = 2'd0; src_vld[0] = 1'b1; csr_en = 1'b1;
        tick(1);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0;
        tick(255);
        chk("b256_not_done", 64'(hi_done), 64'h0);
        tick(1);
        chk("b256_done", 64'(hi_done), 64'h1);
        csr_en = 1'b0;
        tick(1);

        // overflow counter saturation
        csr_mode = 1'b0; peer_vld = 1'b1; csr_en = 1'b1;
        tick(300);
        chk("ovf_sat", 64'(lo_ovf), 64'hFF);
        csr_en = 1'b0;
        tick(1);

        // asynchronous reset in the middle of a burst
        csr_mode = 1'b1; csr_blen = 8'd20; csr_en = 1'b1;
        tick(1);
        trig_in = 1'b1;
        tick(1);
        trig_in = 1'b0; peer_vld = 1'b0;
        tick(3);
        @(posedge rclk);
        #3 arst_l = 1'b0;
        #1;
        chk("arst_hi_bus", 64'(hi_bus), 64'h0);
        chk("arst_lo_bus", 64'(lo_bus), 64'h0);
        chk("arst_lo_ovf", 64'(lo_ovf), 64'h0);
        chk("arst_done", 64'(hi_done), 64'h0);
        tick(1);
        arst_l = 1'b1;
        tick(4);
        chk("post_rst_hi", 64'(hi_bus), 64'h0);
        chk("post_rst_lo", 64'(lo_bus), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
